// File: rtl/picosoc_bus_fabric_pkg.sv
// Shared definitions for the PicoRV32 native-bus slave fabric.
//   - Bus width constants (address, data, byte strobes).
//   - FSM state encoding used by the fabric controller.
//   - Default error read-data pattern.
//   - clog2_min1(): ceil(log2(v)) but never below 1, for index/counter widths.
package picosoc_bus_fabric_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [DATA_W-1:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_ACTIVE = 2'd1,
    BUS_RESP   = 2'd2,
    BUS_ERR    = 2'd3
  } bus_state_e;

  // Width needed to hold an index/count, with a floor of one bit so that
  // degenerate configurations (one slave, watchdog disabled) still elaborate.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/picosoc_bus_fabric_if.sv
// Bundle of the PicoRV32 native memory bus as seen on both sides of the fabric.
//   mem_* : master (cpu) side  - valid/instr/addr/wdata/wstrb in, ready/rdata out
//   s_*   : slave side         - one-hot valid, broadcast instr/addr/wdata/wstrb,
//                                per-slave ready, packed per-slave rdata
// Modports:
//   slave  : the fabric (it is the slave of the cpu bus and drives the s_* side)
//   master : the environment (cpu plus the attached slave devices)
interface picosoc_bus_fabric_if #(
  parameter int NUM_SLAVES = 4
);
  import picosoc_bus_fabric_pkg::*;

  logic                         mem_valid;
  logic                         mem_instr;
  logic                         mem_ready;
  logic [ADDR_W-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_wdata;
  logic [STRB_W-1:0]            mem_wstrb;
  logic [DATA_W-1:0]            mem_rdata;

  logic [NUM_SLAVES-1:0]        s_valid;
  logic                         s_instr;
  logic [ADDR_W-1:0]            s_addr;
  logic [DATA_W-1:0]            s_wdata;
  logic [STRB_W-1:0]            s_wstrb;
  logic [NUM_SLAVES-1:0]        s_ready;
  logic [DATA_W*NUM_SLAVES-1:0] s_rdata;

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    output s_valid, s_instr, s_addr, s_wdata, s_wstrb,
    input  s_ready, s_rdata
  );

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    input  s_valid, s_instr, s_addr, s_wdata, s_wstrb,
    output s_ready, s_rdata
  );

endinterface

// File: rtl/picosoc_bus_decode.sv
// Purely combinational table-driven address decoder.
// Slave i hits when (addr & mask_i) == (base_i & mask_i); on overlap the
// lowest index wins. Kept free of any fabric state so multi-master fabrics
// can instantiate one per master.
// Ports:
//   addr : address to decode
//   base : packed per-slave base addresses, slave i at [32*i +: 32]
//   mask : packed per-slave compare masks,  slave i at [32*i +: 32]
//   hit  : at least one slave matched
//   idx  : index of the winning slave (0 when hit is low)
module picosoc_bus_decode
  import picosoc_bus_fabric_pkg::*;
#(
  parameter  int NUM_SLAVES = 4,
  localparam int IDX_W      = clog2_min1(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0]            addr,
  input  logic [ADDR_W*NUM_SLAVES-1:0] base,
  input  logic [ADDR_W*NUM_SLAVES-1:0] mask,
  output logic                         hit,
  output logic [IDX_W-1:0]             idx
);

  logic [NUM_SLAVES-1:0] match;

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
      assign match[gi] = ((addr & mask[ADDR_W*gi +: ADDR_W]) ==
                          (base[ADDR_W*gi +: ADDR_W] & mask[ADDR_W*gi +: ADDR_W]));
    end
  endgenerate

  // Scan from the top down so the last (lowest) matching index is kept.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/picosoc_bus_fabric.sv
// Slave-side interconnect for the PicoRV32 native memory bus.
// A single outstanding request is decoded against an N-entry base/mask table,
// forwarded with a one-hot s_valid, and answered with a registered response.
// Unmapped accesses and slaves that stall longer than TIMEOUT_CYCLES are
// answered with ERR_RDATA and recorded in a sticky err_flag / err_addr.
// Optional build macro: PICOSOC_BUS_FABRIC_WPROT_EN adds the SLAVE_RO
// parameter; writes to a read-only slave are rejected before reaching it.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : native bus bundle (slave modport: mem_* from cpu, s_* to slaves)
//   err_clr    : clears err_flag (a simultaneous new error takes precedence)
//   err_flag   : sticky error indicator
//   err_addr   : address of the most recent error
module picosoc_bus_fabric
  import picosoc_bus_fabric_pkg::*;
#(
  parameter int                           NUM_SLAVES     = 4,
  parameter logic [ADDR_W*NUM_SLAVES-1:0] SLAVE_BASE     = {NUM_SLAVES{32'h0}},
  parameter logic [ADDR_W*NUM_SLAVES-1:0] SLAVE_MASK     = {NUM_SLAVES{32'hFFFF_FFFF}},
  parameter int                           TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0]            ERR_RDATA      = DEFAULT_ERR_RDATA
`ifdef PICOSOC_BUS_FABRIC_WPROT_EN
  ,
  parameter logic [NUM_SLAVES-1:0]        SLAVE_RO       = '0
`endif
) (
  input  logic                clk,
  input  logic                reset,
  picosoc_bus_fabric_if.slave bus,
  input  logic                err_clr,
  output logic                err_flag,
  output logic [ADDR_W-1:0]   err_addr
);

  localparam int IDX_W = clog2_min1(NUM_SLAVES);
  localparam int CNT_W = clog2_min1(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] IDLE   = BUS_IDLE;
  localparam logic [1:0] ACTIVE = BUS_ACTIVE;
  localparam logic [1:0] RESP   = BUS_RESP;
  localparam logic [1:0] ERR    = BUS_ERR;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [1:0]            state_reg,     state_next;
  logic [IDX_W-1:0]      sel_reg,       sel_next;
  logic [NUM_SLAVES-1:0] s_valid_reg,   s_valid_next;
  logic                  s_instr_reg,   s_instr_next;
  logic [ADDR_W-1:0]     s_addr_reg,    s_addr_next;
  logic [DATA_W-1:0]     s_wdata_reg,   s_wdata_next;
  logic [STRB_W-1:0]     s_wstrb_reg,   s_wstrb_next;
  logic                  mem_ready_reg, mem_ready_next;
  logic [DATA_W-1:0]     mem_rdata_reg, mem_rdata_next;
  logic                  err_flag_reg,  err_flag_next;
  logic [ADDR_W-1:0]     err_addr_reg,  err_addr_next;
  logic [CNT_W-1:0]      tmo_cnt_reg,   tmo_cnt_next;

  // ---------------------------------------------------------------------
  // Decode of the live master address (only consulted in IDLE)
  // ---------------------------------------------------------------------
  logic                  dec_hit;
  logic [IDX_W-1:0]      dec_idx;
  logic [NUM_SLAVES-1:0] dec_onehot;
  logic                  wprot_block;

  picosoc_bus_decode #(
    .NUM_SLAVES (NUM_SLAVES)
  ) u_decode (
    .addr (bus.mem_addr),
    .base (SLAVE_BASE),
    .mask (SLAVE_MASK),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_onehot
      assign dec_onehot[gi] = dec_hit && (dec_idx == IDX_W'(gi));
    end
  endgenerate

`ifdef PICOSOC_BUS_FABRIC_WPROT_EN
  // A write aimed at a read-only slave is turned into an error response
  // without ever raising that slave's s_valid.
  assign wprot_block = (bus.mem_wstrb != '0) && (|(SLAVE_RO & dec_onehot));
`else
  assign wprot_block = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Selected slave's ready/rdata; other slaves' ready is ignored.
  // ---------------------------------------------------------------------
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_reg == IDX_W'(i)) begin
        sel_ready = bus.s_ready[i];
        sel_rdata = bus.s_rdata[DATA_W*i +: DATA_W];
      end
    end
  end

  // Watchdog fires when the count, including the current ACTIVE cycle,
  // reaches TIMEOUT_CYCLES; zero disables it.
  logic tmo_hit;
  assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                   ((32'(tmo_cnt_reg) + 32'd1) == 32'(TIMEOUT_CYCLES));

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    s_valid_next   = s_valid_reg;
    s_instr_next   = s_instr_reg;
    s_addr_next    = s_addr_reg;
    s_wdata_next   = s_wdata_reg;
    s_wstrb_next   = s_wstrb_reg;
    mem_ready_next = 1'b0;
    mem_rdata_next = mem_rdata_reg;
    err_addr_next  = err_addr_reg;
    tmo_cnt_next   = tmo_cnt_reg;
    // Clear first so that an error raised below in the same cycle wins.
    err_flag_next  = err_clr ? 1'b0 : err_flag_reg;

    case (state_reg)
      IDLE: begin
        if (bus.mem_valid) begin
          s_instr_next = bus.mem_instr;
          s_addr_next  = bus.mem_addr;
          s_wdata_next = bus.mem_wdata;
          s_wstrb_next = bus.mem_wstrb;
          if (dec_hit && !wprot_block) begin
            s_valid_next = dec_onehot;
            sel_next     = dec_idx;
            tmo_cnt_next = '0;
            state_next   = ACTIVE;
          end else begin
            state_next     = ERR;
            mem_ready_next = 1'b1;
            mem_rdata_next = ERR_RDATA;
            err_flag_next  = 1'b1;
            err_addr_next  = bus.mem_addr;
          end
        end
      end

      ACTIVE: begin
        tmo_cnt_next = tmo_cnt_reg + CNT_W'(1);
        if (sel_ready) begin
          mem_rdata_next = sel_rdata;
          mem_ready_next = 1'b1;
          s_valid_next   = '0;
          state_next     = RESP;
        end else if (tmo_hit) begin
          s_valid_next   = '0;
          state_next     = ERR;
          mem_ready_next = 1'b1;
          mem_rdata_next = ERR_RDATA;
          err_flag_next  = 1'b1;
          err_addr_next  = s_addr_reg;
        end
      end

      // mem_ready was registered on entry, so both states last one cycle.
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      s_valid_reg   <= '0;
      s_instr_reg   <= 1'b0;
      s_addr_reg    <= '0;
      s_wdata_reg   <= '0;
      s_wstrb_reg   <= '0;
      mem_ready_reg <= 1'b0;
      mem_rdata_reg <= '0;
      err_flag_reg  <= 1'b0;
      err_addr_reg  <= '0;
      tmo_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      s_valid_reg   <= s_valid_next;
      s_instr_reg   <= s_instr_next;
      s_addr_reg    <= s_addr_next;
      s_wdata_reg   <= s_wdata_next;
      s_wstrb_reg   <= s_wstrb_next;
      mem_ready_reg <= mem_ready_next;
      mem_rdata_reg <= mem_rdata_next;
      err_flag_reg  <= err_flag_next;
      err_addr_reg  <= err_addr_next;
      tmo_cnt_reg   <= tmo_cnt_next;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.mem_ready = mem_ready_reg;
  assign bus.mem_rdata = mem_rdata_reg;
  assign bus.s_valid   = s_valid_reg;
  assign bus.s_instr   = s_instr_reg;
  assign bus.s_addr    = s_addr_reg;
  assign bus.s_wdata   = s_wdata_reg;
  assign bus.s_wstrb   = s_wstrb_reg;
  assign err_flag      = err_flag_reg;
  assign err_addr      = err_addr_reg;

endmodule

// File: tb/tb_picosoc_bus_fabric.sv
// Self-checking bench for picosoc_bus_fabric: directed cases followed by
// randomized transactions, compared against a transaction-level reference
// (address table lookup, per-slave memory arrays, latency arithmetic).
module tb_picosoc_bus_fabric;

  localparam int NS  = 4;
  localparam int TMO = 8;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

  // Slave map: 0 = 4 KiB at 0, 1 = 16 MiB at 0x0100_0000,
  // 2 = 16 MiB at 0x0200_0000, 3 = 16 MiB at 0 (overlaps slave 0).
  localparam logic [31:0] BASE_T [NS] = '{32'h0000_0000, 32'h0100_0000, 32'h0200_0000, 32'h0000_0000};
  localparam logic [31:0] MASK_T [NS] = '{32'hFFFF_F000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000};
`ifdef PICOSOC_BUS_FABRIC_WPROT_EN
  localparam logic [NS-1:0] RO = 4'b0010;
`else
  localparam logic [NS-1:0] RO = 4'b0000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        err_clr;
  logic        err_flag;
  logic [31:0] err_addr;

  picosoc_bus_fabric_if #(.NUM_SLAVES(NS)) bus ();

  picosoc_bus_fabric #(
    .NUM_SLAVES     (NS),
    .SLAVE_BASE     ({BASE_T[3], BASE_T[2], BASE_T[1], BASE_T[0]}),
    .SLAVE_MASK     ({MASK_T[3], MASK_T[2], MASK_T[1], MASK_T[0]}),
    .TIMEOUT_CYCLES (TMO),
    .ERR_RDATA      (ERRV)
`ifdef PICOSOC_BUS_FABRIC_WPROT_EN
    ,
    .SLAVE_RO       (RO)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .err_clr  (err_clr),
    .err_flag (err_flag),
    .err_addr (err_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Slave devices' storage and the reference model's view of it.
  logic [31:0] slave_mem [NS][16];
  logic [31:0] ref_mem   [NS][16];
  logic        ref_err_flag;
  logic [31:0] ref_err_addr;

  function automatic int ref_target(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & MASK_T[i]) == (BASE_T[i] & MASK_T[i])) return i;
    return -1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // One full transaction. Called right after a posedge+1; cycle 0 is the
  // cycle the request is presented in.
  task automatic run_txn(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input bit instr, input int wait_n, input bit clr);
    int          tgt, widx, exp_lat, exp_cnt, lat, sv_cnt;
    bit          is_err, stable;
    logic [31:0] exp_rdata, got_rdata, got_eaddr;
    logic [NS-1:0] exp_oh, acc, sv;
    logic        got_flag;

    tgt  = ref_target(addr);
    widx = int'(addr[5:2]);
    is_err  = (tgt < 0) || ((wstrb != 0) && RO[tgt]);
    exp_oh  = '0;
    if (is_err) begin
      exp_lat = 1; exp_cnt = 0; exp_rdata = ERRV;
    end else begin
      exp_oh[tgt] = 1'b1;
      if (wait_n + 1 > TMO) begin
        exp_lat = TMO + 1; exp_cnt = TMO; exp_rdata = ERRV; is_err = 1;
      end else begin
        exp_lat = wait_n + 2; exp_cnt = wait_n + 1; exp_rdata = ref_mem[tgt][widx];
        if (wstrb != 0) ref_mem[tgt][widx] = merge(ref_mem[tgt][widx], wdata, wstrb);
      end
    end
    if (is_err) begin
      ref_err_flag = 1'b1;
      ref_err_addr = addr;
    end else if (clr) begin
      ref_err_flag = 1'b0;
    end

    bus.mem_valid = 1'b1; bus.mem_addr = addr; bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb; bus.mem_instr = instr; err_clr = clr;
    lat = 0; sv_cnt = 0; acc = '0; stable = 1'b1;
    got_rdata = '0; got_flag = 1'b0; got_eaddr = '0;

    for (int cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
      @(posedge clk); #1;
      err_clr = 1'b0;
      sv  = bus.s_valid;
      acc = acc | sv;
      if (sv != 0)
        stable &= (bus.s_addr == addr) && (bus.s_wdata == wdata) &&
                  (bus.s_wstrb == wstrb) && (bus.s_instr == instr);
      if (tgt >= 0 && sv[tgt]) sv_cnt++;
      // Unselected slaves chatter on ready/rdata; the fabric must ignore them.
      bus.s_ready = '0;
      for (int j = 0; j < NS; j++) begin
        if (j != tgt) begin
          bus.s_ready[j] = ($urandom_range(0, 3) == 0);
          bus.s_rdata[32*j +: 32] = $urandom;
        end
      end
      if (bus.mem_ready) begin
        lat = cyc; got_rdata = bus.mem_rdata; got_flag = err_flag; got_eaddr = err_addr;
        bus.mem_valid = 1'b0;
      end else if (tgt >= 0 && sv[tgt] && sv_cnt == wait_n + 1) begin
        bus.s_ready[tgt] = 1'b1;
        bus.s_rdata[32*tgt +: 32] = slave_mem[tgt][widx];
        if (wstrb != 0) slave_mem[tgt][widx] = merge(slave_mem[tgt][widx], wdata, wstrb);
      end
    end
    bus.mem_valid = 1'b0;
    bus.s_ready   = '0;

    check({name, "/ready_seen"}, 32'(lat != 0), 32'd1);
    check({name, "/latency"},    32'(lat), 32'(exp_lat));
    check({name, "/rdata"},      got_rdata, exp_rdata);
    check({name, "/s_valid_sel"}, 32'(acc), 32'(exp_oh));
    check({name, "/s_valid_cycles"}, 32'(sv_cnt), 32'(exp_cnt));
    check({name, "/bus_stable"}, 32'(stable), 32'd1);
    check({name, "/err_flag"},   32'(got_flag), 32'(ref_err_flag));
    check({name, "/err_addr"},   got_eaddr, ref_err_addr);
    @(posedge clk); #1;
    check({name, "/ready_pulse"}, {bus.s_valid, 3'b0, bus.mem_ready}, 32'd0);
    $display("txn %-10s addr=%h wstrb=%h wait=%0d lat=%0d rdata=%h err=%0d",
             name, addr, wstrb, wait_n, lat, got_rdata, got_flag);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    ref_err_flag = 1'b0;
    check("err_clr", 32'(err_flag), 32'(ref_err_flag));
    check("err_clr/addr_kept", err_addr, ref_err_addr);
    $display("txn err_clr    err_flag=%0d", err_flag);
  endtask

  task automatic reset_mid_txn();
    bit seen;
    bus.mem_valid = 1'b1; bus.mem_addr = 32'h0100_0040; bus.mem_wstrb = 4'h0;
    bus.mem_wdata = 32'h0; bus.mem_instr = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("rst/s_valid_before", 32'(bus.s_valid), 32'h2);
    reset = 1'b1; bus.mem_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    ref_err_flag = 1'b0; ref_err_addr = '0;
    check("rst/s_valid_after", 32'(bus.s_valid), 32'h0);
    check("rst/err_flag", 32'(err_flag), 32'(ref_err_flag));
    check("rst/err_addr", err_addr, ref_err_addr);
    seen = bus.mem_ready;
    repeat (4) begin @(posedge clk); #1; seen |= bus.mem_ready; end
    check("rst/no_ready", 32'(seen), 32'd0);
    $display("txn reset_mid  s_valid=%b ready_seen=%0d", bus.s_valid, seen);
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [3:0]  st;
    int          r, w;
    int          waits [7] = '{0, 1, 2, 3, 7, 8, 20};

    for (int s = 0; s < NS; s++)
      for (int k = 0; k < 16; k++) begin
        slave_mem[s][k] = $urandom;
        ref_mem[s][k]   = slave_mem[s][k];
      end
    ref_err_flag = 1'b0; ref_err_addr = '0;

    reset = 1'b1; err_clr = 1'b0;
    bus.mem_valid = 1'b0; bus.mem_instr = 1'b0; bus.mem_addr = '0;
    bus.mem_wdata = '0; bus.mem_wstrb = '0; bus.s_ready = '0; bus.s_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/mem_ready", 32'(bus.mem_ready), 32'd0);
    check("reset/mem_rdata", bus.mem_rdata, 32'd0);
    check("reset/s_valid",   32'(bus.s_valid), 32'd0);
    check("reset/err_flag",  32'(err_flag), 32'd0);
    check("reset/err_addr",  err_addr, 32'd0);
    reset = 1'b0;

    // Directed cases.
    slave_mem[0][4] = 32'h1234_5678; ref_mem[0][4] = 32'h1234_5678;
    run_txn("ram_rd",   32'h0000_0010, 32'h0, 4'h0, 1'b1, 0, 1'b0);
    run_txn("wait_wr",  32'h0200_0008, 32'hA5A5_A5A5, 4'b0011, 1'b0, 5, 1'b0);
    run_txn("wait_rd",  32'h0200_0008, 32'h0, 4'h0, 1'b0, 1, 1'b0);
    run_txn("unmapped", 32'h0F00_0000, 32'h5555_5555, 4'hF, 1'b0, 0, 1'b0);
    pulse_clr();
    run_txn("timeout",  32'h0100_0004, 32'h0, 4'h0, 1'b0, 100, 1'b0);
    run_txn("after_to", 32'h0000_0010, 32'h0, 4'h0, 1'b0, 0, 1'b0);
    run_txn("edge_w7",  32'h0100_000C, 32'h0, 4'h0, 1'b0, 7, 1'b0);
    run_txn("overlap",  32'h0000_0100, 32'h0, 4'h0, 1'b0, 2, 1'b0);
    run_txn("slave3",   32'h0000_2000, 32'h0, 4'h0, 1'b0, 0, 1'b0);
    run_txn("clr_err",  32'h0F12_3450, 32'h0, 4'h0, 1'b0, 0, 1'b1);
    run_txn("ro_wr",    32'h0100_0010, 32'hCAFE_F00D, 4'hF, 1'b0, 0, 1'b0);
    run_txn("ro_rd",    32'h0100_0010, 32'h0, 4'h0, 1'b0, 0, 1'b0);
    reset_mid_txn();

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      r  = $urandom_range(0, 4);
      wd = $urandom;
      st = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      w  = waits[$urandom_range(0, 6)];
      a  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      case (r)
        0: a = 32'h0000_0000 | a;
        1: a = 32'h0100_0000 | a;
        2: a = 32'h0200_0000 | a;
        3: a = 32'h0000_2000 | a;
        default: a = 32'h0F00_0000 | ($urandom & 32'h00FF_FFFC);
      endcase
      run_txn("rand", a, wd, st, (st == 0) && ($urandom_range(0, 1) == 1), w,
              ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/picosoc_bus_fabric.md
Name: picosoc_bus_fabric

Overview:
- Parametrised slave-side interconnect for the PicoRV32 native memory bus (valid/ready/addr/wdata/wstrb/rdata).
- Replaces hard-coded address compares and ready/rdata muxing with an N-slave table-driven decoder.
- Adds registered responses, a per-transaction timeout watchdog, and error responses for unmapped or stalled accesses.
- Sits between the cpu instance and RAM, flash XIP, UART/config registers and iomem.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..16).
- SLAVE_BASE, {NUM_SLAVES{32'h0}}, packed 32-bit base address per slave; slave i occupies bits [32*i+:32].
- SLAVE_MASK, {NUM_SLAVES{32'hFFFF_FFFF}}, packed 32-bit compare mask per slave; slave i hits when (mem_addr & mask_i) == (base_i & mask_i).
- TIMEOUT_CYCLES, 255, maximum cycles s_valid is held without s_ready; 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on an error response.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high reset.
- mem_valid, input, 1, master request.
- mem_instr, input, 1, master instruction-fetch flag; forwarded to slaves unchanged.
- mem_ready, output, 1, master response strobe.
- mem_addr, input, 32, master address.
- mem_wdata, input, 32, master write data.
- mem_wstrb, input, 4, master byte strobes; 0 means read.
- mem_rdata, output, 32, master read data.
- s_valid, output, NUM_SLAVES, one-hot slave request.
- s_instr, output, 1, broadcast instruction-fetch flag.
- s_addr, output, 32, broadcast address.
- s_wdata, output, 32, broadcast write data.
- s_wstrb, output, 4, broadcast byte strobes.
- s_ready, input, NUM_SLAVES, per-slave ready.
- s_rdata, input, 32*NUM_SLAVES, packed per-slave read data.
- err_clr, input, 1, clears err_flag.
- err_flag, output, 1, sticky error indicator.
- err_addr, output, 32, address of the most recent error.

Behaviour:
- Reset (synchronous, active-high) values:
  - State IDLE.
  - mem_ready=0, mem_rdata=0, s_valid=0.
  - err_flag=0, err_addr=0, timeout counter=0.
- Reset mid-transaction drops s_valid on the next edge; no response is issued to the master.
- Address decode:
  - Combinational priority decoder; the lowest matching index wins on overlap.
  - No match means unmapped.
- FSM states: IDLE, ACTIVE, RESP, ERR.
  - IDLE: when mem_valid=1, latch addr/wdata/wstrb/instr onto the s_* regs.
    - Decode hit i: assert s_valid[i], go to ACTIVE.
    - No hit: go to ERR.
  - ACTIVE: s_valid[i] is held; s_* are stable.
    - On s_ready[i]=1: register s_rdata[i] into mem_rdata, drop s_valid, go to RESP.
    - s_ready of non-selected slaves is ignored.
    - Timeout counter increments each ACTIVE cycle. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES with no ready: drop s_valid, go to ERR.
  - RESP: mem_ready=1 for exactly one cycle, then IDLE.
  - ERR: mem_ready=1 for one cycle, mem_rdata=ERR_RDATA, err_flag<=1, err_addr<=latched address; then IDLE.
- Write data is never committed on an error.
- Latency:
  - Request sampled in cycle 0; s_valid asserted in cycle 1.
  - A slave readying in cycle k gives mem_ready in cycle k+1.
  - A zero-wait slave gives mem_ready in cycle 2.
  - Unmapped access gives mem_ready in cycle 1.
- mem_rdata holds its last value outside RESP/ERR. On writes it is don't-care but deterministic (the registered slave rdata).
- Back-to-back: IDLE may accept a new request in the cycle after RESP/ERR. The master drops valid for at least that cycle.
- err_clr and a simultaneous new error: the error wins and err_flag stays 1.
- The timeout counter clears on every entry to ACTIVE. Its width is $clog2(TIMEOUT_CYCLES+1), minimum 1.

Optional Feature:
- Macro: PICOSOC_BUS_FABRIC_WPROT_EN.
- Defined:
  - Adds parameter SLAVE_RO (NUM_SLAVES bits, default 0).
  - A write (mem_wstrb!=0) decoding to slave i with SLAVE_RO[i]=1 goes IDLE→ERR; s_valid is never asserted.
  - Reads to that slave are unaffected.
- Undefined: no SLAVE_RO parameter; all slaves are writable.

Decomposition:
- Package picosoc_bus_fabric_pkg:
  - FSM state enum (IDLE/ACTIVE/RESP/ERR).
  - Bus width constants: ADDR_W=32, DATA_W=32, STRB_W=4.
  - Default ERR_RDATA constant.
- Sub-module picosoc_bus_decode: purely combinational priority decoder.
  - Inputs: addr, base and mask vectors.
  - Outputs: hit and idx.
  - Reused by future multi-master fabrics.

Test Plan:
- Default map with a zero-wait RAM at slave 0: read 0x0000_0010 returning 0x1234_5678 → s_valid[0] in cycle 1, mem_ready in cycle 2, mem_rdata=0x1234_5678, err_flag=0.
- Slave 2 readies after 5 wait cycles on a write of 0xA5A5_A5A5 with wstrb=4'b0011 → s_wdata/s_wstrb stable through ACTIVE, mem_ready in cycle 7, single-cycle pulse.
- Unmapped address 0x0F00_0000 → mem_ready in cycle 1, mem_rdata=0xDEAD_BEEF, err_flag=1, err_addr=0x0F00_0000, no s_valid; then err_clr → err_flag=0.
- TIMEOUT_CYCLES=8 with slave 1 never ready → s_valid[1] high exactly 8 cycles, then ERR response; a following read to slave 0 succeeds normally.
- Overlapping slaves 0 and 3 both match 0x0000_0100 → only s_valid[0] asserted. Reset asserted in ACTIVE → s_valid=0 next cycle, no mem_ready.
- With PICOSOC_BUS_FABRIC_WPROT_EN and SLAVE_RO=4'b0010: write to slave 1 → ERR, s_valid[1] never high; read to slave 1 → normal RESP.
